// File: rtl/in_debounce_filter.sv
// in_debounce_filter
//   Conditions the asynchronous, possibly bouncing raw_in line for the
//   sequence FSM. raw_in passes through a two-flop synchronizer. A level
//   change is accepted only after it has been seen on DEBOUNCE_CYCLES
//   consecutive enabled samples. Each accepted change produces a one-cycle
//   edge pulse.
//
//   Optional feature macro: IN_FILTER_GLITCH_CNT_EN
//     When it is defined, glitch_cnt counts rejected pulses and saturates at
//     255. When it is undefined, glitch_cnt is tied to 0 and no counter
//     register is built.
//
// Ports
//   clk         clock; all logic runs on the rising edge
//   rst         asynchronous, active-high reset
//   en          sample enable; the filter state only advances when en is high
//   raw_in      asynchronous raw input line
//   in_clean    debounced level; drives the sequence FSM `in` input
//   rise_pulse  one-cycle pulse in the first cycle in_clean reads 1
//   fall_pulse  one-cycle pulse in the first cycle in_clean reads 0
//   glitch_cnt  8-bit count of rejected pulses (0 when the feature is off)
module in_debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       raw_in,
  output logic       in_clean,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    PEND_HI = 2'd1,
    HIGH    = 2'd2,
    PEND_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             in_clean_nxt;
  logic             rise_nxt;
  logic             fall_nxt;
  logic             glitch;

  // Synchronizer stage: runs every cycle, independent of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Debounce FSM next-state stage
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    glitch    = 1'b0;
    if (en) begin
      case (state)
        LOW: begin
          if (s2) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_nxt = HIGH;
              cnt_nxt   = '0;
              rise_nxt  = 1'b1;
            end else begin
              state_nxt = PEND_HI;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        PEND_HI: begin
          if (!s2) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
            glitch    = 1'b1;
          end else if (cnt == CNT_LAST) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
            rise_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!s2) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_nxt = LOW;
              cnt_nxt   = '0;
              fall_nxt  = 1'b1;
            end else begin
              state_nxt = PEND_LO;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        PEND_LO: begin
          if (s2) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
            glitch    = 1'b1;
          end else if (cnt == CNT_LAST) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
            fall_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      endcase
    end
    // The accepted level is high while settled high or while a fall is
    // still being qualified.
    in_clean_nxt = (state_nxt == HIGH) || (state_nxt == PEND_LO);
  end

  // State and registered output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOW;
      cnt        <= '0;
      in_clean   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      in_clean   <= in_clean_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

`ifdef IN_FILTER_GLITCH_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] glitch_q;

  // Glitch counter stage: counts on the same edge as the abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_q <= '0;
    end else if (glitch) begin
      glitch_q <= sat_inc(glitch_q);
    end
  end

  assign glitch_cnt = glitch_q;
`else
  logic glitch_unused;
  assign glitch_unused = glitch;
  assign glitch_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_in_debounce_filter.sv
module tb_in_debounce_filter;

`ifdef IN_FILTER_GLITCH_CNT_EN
  localparam int GLITCH_ON = 1;
`else
  localparam int GLITCH_ON = 0;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic       raw_in;
  logic       in_clean4, rise4, fall4;
  logic [7:0] glitch4;
  logic       in_clean1, rise1, fall1;
  logic [7:0] glitch1;
  logic       mon_on;

  int n_checks = 0;
  int n_errors = 0;

  in_debounce_filter #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .raw_in(raw_in),
    .in_clean(in_clean4), .rise_pulse(rise4), .fall_pulse(fall4),
    .glitch_cnt(glitch4)
  );

  in_debounce_filter #(.DEBOUNCE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .en(en), .raw_in(raw_in),
    .in_clean(in_clean1), .rise_pulse(rise1), .fall_pulse(fall1),
    .glitch_cnt(glitch1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the accepted level flips once the synchronized input
  // has disagreed with it for dc enabled samples in a row; a disagreeing
  // run that ends early counts as one rejected pulse.
  typedef struct packed {
    logic       s1;
    logic       s2;
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] run;
    logic [7:0] glitch;
  } mdl_t;

  function automatic mdl_t mdl_next(mdl_t m, logic en_i, logic raw_i, int dc);
    mdl_t n;
    n      = m;
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (en_i) begin
      if (m.s2 != m.level) begin
        n.run = m.run + 8'd1;
        if (int'(n.run) == dc) begin
          n.level = m.s2;
          n.rise  = m.s2;
          n.fall  = !m.s2;
          n.run   = '0;
        end
      end else if (m.run != 0) begin
        n.run = '0;
        if (m.glitch != 8'd255) n.glitch = m.glitch + 8'd1;
      end
    end
    n.s2 = m.s1;
    n.s1 = raw_i;
    return n;
  endfunction

  mdl_t m4, m1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4 <= '0;
      m1 <= '0;
    end else begin
      m4 <= mdl_next(m4, en, raw_in, 4);
      m1 <= mdl_next(m1, en, raw_in, 1);
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      check("clean4", int'(in_clean4), int'(m4.level));
      check("rise4", int'(rise4), int'(m4.rise));
      check("fall4", int'(fall4), int'(m4.fall));
      check("glitch4", int'(glitch4), GLITCH_ON ? int'(m4.glitch) : 0);
      check("excl4", int'(rise4 & fall4), 0);
      check("clean1", int'(in_clean1), int'(m1.level));
      check("rise1", int'(rise1), int'(m1.rise));
      check("fall1", int'(fall1), int'(m1.fall));
      check("glitch1", int'(glitch1), 0);
      check("excl1", int'(rise1 & fall1), 0);
    end
  end

  initial begin
    int rises;
    int run_left;
    clk    = 1'b0;
    rst    = 1'b0;
    en     = 1'b1;
    raw_in = 1'b0;
    mon_on = 1'b0;
    run_left = 0;

    // Reset, then idle
    #2 rst = 1'b1;
    #1 mon_on = 1'b1;
    #1;
    check("rst_clean", int'(in_clean4), 0);
    check("rst_rise", int'(rise4), 0);
    check("rst_fall", int'(fall4), 0);
    check("rst_glitch", int'(glitch4), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_clean", int'(in_clean4), 0);
    check("idle_glitch", int'(glitch4), 0);

    // Clean rise: raw_in changes before edge 0, in_clean at edge 5
    raw_in = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      check("lat_clean", int'(in_clean4), (e == 5) ? 1 : 0);
      check("lat_rise", int'(rise4), (e == 5) ? 1 : 0);
    end
    @(posedge clk); #1;
    check("rise_once", int'(rise4), 0);
    check("rise_hold", int'(in_clean4), 1);

    // Clean fall
    @(negedge clk);
    raw_in = 1'b0;
    @(posedge clk);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      check("fall_clean", int'(in_clean4), (e == 5) ? 0 : 1);
      check("fall_pulse", int'(fall4), (e == 5) ? 1 : 0);
    end

    // Bounce: high 3, low 2, then high held
    repeat (3) @(negedge clk);
    raw_in = 1'b1;
    repeat (3) @(negedge clk);
    raw_in = 1'b0;
    repeat (2) @(negedge clk);
    raw_in = 1'b1;
    rises = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (rise4) rises++;
      if (e == 4) check("bnc_early", int'(in_clean4), 0);
      if (e == 5) check("bnc_clean", int'(in_clean4), 1);
    end
    check("bnc_rises", rises, 1);
    check("bnc_glitch", int'(glitch4), GLITCH_ON);

    // Enable gating with raw_in held high
    @(negedge clk);
    raw_in = 1'b0;
    repeat (10) @(negedge clk);
    check("gate_start", int'(in_clean4), 0);
    raw_in = 1'b1;
    for (int i = 0; i < 14; i++) begin
      en = ~en;
      @(negedge clk);
    end
    en = 1'b1;
    check("gate_end", int'(in_clean4), 1);

    // Reset while pending with cnt=2
    raw_in = 1'b0;
    repeat (10) @(negedge clk);
    raw_in = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mrst_clean", int'(in_clean4), 0);
    check("mrst_rise", int'(rise4), 0);
    check("mrst_glitch", int'(glitch4), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      @(posedge clk); #1;
      check("mrst_win", int'(in_clean4), (e == 5) ? 1 : 0);
    end

    // DEBOUNCE_CYCLES=1: one-cycle raw pulse passes through
    @(negedge clk);
    raw_in = 1'b0;
    repeat (10) @(negedge clk);
    raw_in = 1'b1;
    @(negedge clk);
    raw_in = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("dc1_clean_hi", int'(in_clean1), 1);
    check("dc1_rise", int'(rise1), 1);
    @(posedge clk); #1;
    check("dc1_clean_lo", int'(in_clean1), 0);
    check("dc1_fall", int'(fall1), 1);
    check("dc1_rise_off", int'(rise1), 0);
    check("dc1_glitch", int'(glitch1), 0);

    // Randomized runs, gated enable, occasional reset
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 7) != 0);
      if (run_left == 0) begin
        raw_in   = ~raw_in;
        run_left = $urandom_range(1, 7);
      end
      run_left--;
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end

    // Saturation: 300 short pulses, all rejected by the 4-sample filter
    @(negedge clk);
    en     = 1'b1;
    raw_in = 1'b0;
    repeat (10) @(negedge clk);
    for (int g = 0; g < 300; g++) begin
      raw_in = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      raw_in = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("sat_glitch", int'(glitch4), GLITCH_ON ? 255 : 0);
    check("sat_clean", int'(in_clean4), 0);
    check("sat_glitch1", int'(glitch1), 0);

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/in_debounce_filter.md
# in_debounce_filter

Input conditioner upstream of the sequence FSM: takes the asynchronous, possibly bouncing `raw_in` line, synchronizes it, and produces the clean level `in_clean` that drives the FSM's `in` input. It also produces single-cycle edge pulses. A level change is accepted only after it has been stable for `DEBOUNCE_CYCLES` consecutive enabled samples.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive equal enabled samples needed to accept a level change; legal range 1..2^`CNT_W`-1.
- `CNT_W`, default 4: width of the stability counter.

Ports:
- `clk`  input  1  clock; all logic on posedge.
- `rst`  input  1  reset: asynchronous, active-high; clock `clk`.
- `en`  input  1  sample enable; FSM and counter advance only when high.
- `raw_in`  input  1  asynchronous raw input line.
- `in_clean`  output  1  debounced level; connects to the FSM `in` input.
- `rise_pulse`  output  1  one-cycle pulse when `in_clean` goes 0->1.
- `fall_pulse`  output  1  one-cycle pulse when `in_clean` goes 1->0.
- `glitch_cnt`  output  8  count of rejected pulses; see Configuration.

## Operation
- Synchronizer:
  - Two flops `s1`, `s2`, both reset to 0, clocked every cycle regardless of `en`.
  - `s2` is the only sampled value.
- FSM states: LOW, PEND_HI, HIGH, PEND_LO. Reset state LOW.
- Counter `cnt` resets to 0.
- Transitions happen only on cycles with `en`=1. With `en`=0, state, `cnt` and `in_clean` hold, and both pulses are 0.
- LOW:
  - `s2`=1 and `DEBOUNCE_CYCLES`=1 -> HIGH.
  - `s2`=1 otherwise -> PEND_HI, `cnt`<=1.
  - `s2`=0 -> stay in LOW.
- PEND_HI:
  - `s2`=0 -> LOW. This is a glitch.
  - `s2`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 -> HIGH.
  - Otherwise `cnt`<=`cnt`+1.
- HIGH and PEND_LO: mirror of LOW and PEND_HI with levels inverted. Reaching LOW from PEND_LO completes a fall.
- `in_clean` is registered and equals 1 exactly in states HIGH and PEND_LO.
- `rise_pulse` and `fall_pulse`:
  - Registered; asserted for exactly one cycle, in the first cycle `in_clean` shows the new level.
  - Never both high at once.
- `cnt` is cleared to 0 on entering LOW or HIGH. It never exceeds `DEBOUNCE_CYCLES`-1, so there is no wrap.
- Reset mid-operation: every register returns to its reset value immediately. A pending transition is discarded without a glitch count.
- Reset values: `in_clean`=0, `rise_pulse`=0, `fall_pulse`=0, `glitch_cnt`=0.

## Timing
- Latency, with `en`=1 and `raw_in` changed before edge 0 and then held: `s2` updates at edge 1, and `in_clean` and the pulse update at edge `DEBOUNCE_CYCLES`+1. Default parameters: edge 5.
- With gated `en`: latency is 2 clock edges for synchronization plus `DEBOUNCE_CYCLES` enabled edges.
- Minimum accepted pulse width: `DEBOUNCE_CYCLES` consecutive enabled samples. Anything shorter is rejected and `in_clean` does not change.
- A glitch abort and the `glitch_cnt` increment land on the same edge.

## Configuration
- `IN_FILTER_GLITCH_CNT_EN` defined:
  - `glitch_cnt` increments on every PEND_HI->LOW and PEND_LO->HIGH abort.
  - It saturates at 255 and is cleared only by `rst`.
- Not defined: `glitch_cnt` is driven constant 0 and no counter register is built. All other behaviour is identical.

## Test plan
- Reset then idle: `rst` pulse, `raw_in`=0, `en`=1 for 20 cycles -> `in_clean`=0, no pulses, `glitch_cnt`=0.
- Clean rise, defaults: `raw_in` 0->1 before edge 0 and held -> `in_clean`=1 and `rise_pulse`=1 for one cycle after edge 5. Then `raw_in`->0 -> `fall_pulse` after 5 more edges, `in_clean`=0.
- Bounce: `raw_in` high for 3 cycles, low for 2, then high and held -> one glitch, `glitch_cnt`=1 (macro on) or 0 (macro off), exactly one `rise_pulse`, `in_clean` rises 5 edges after the final rise.
- Enable gating: `en` toggled 1,0,1,0 with `raw_in` held high -> `in_clean` rises only after 4 enabled samples; state holds while `en`=0.
- Reset mid-pending: assert `rst` while in PEND_HI with `cnt`=2 -> all outputs 0 next cycle; after release, a full `DEBOUNCE_CYCLES` window is needed again.
- Boundary, `DEBOUNCE_CYCLES`=1: 1-cycle `raw_in` pulse -> `in_clean` high for exactly 1 cycle, `rise_pulse` and `fall_pulse` on consecutive cycles, `glitch_cnt`=0. Saturation: 300 glitches -> `glitch_cnt`=255.
